// File: rtl/fma_align_pipe_if.sv
// Valid/ready bundle around the fma16 addend aligner: operand side, result side and kill statistics.
interface fma_align_pipe_if #(
    parameter int NE   = 5,
    parameter int NF   = 10,
    parameter int TAGW = 4
);
    localparam int AMW = 3*NF+4;
    localparam int CW  = NE+4;

    logic                 in_valid;
    logic                 in_ready;
    logic [NE-1:0]        xe_i;
    logic [NE-1:0]        ye_i;
    logic [NE-1:0]        ze_i;
    logic [NF:0]          zm_i;
    logic                 xzero_i;
    logic                 yzero_i;
    logic                 zzero_i;
    logic [TAGW-1:0]      tag_i;

    logic                 out_valid;
    logic                 out_ready;
    logic [AMW-1:0]       am_o;
    logic                 asticky_o;
    logic                 killprod_o;
    logic                 killz_o;
    logic signed [CW-1:0] acnt_o;
    logic [TAGW-1:0]      tag_o;
    logic [15:0]          killprod_cnt;
    logic [15:0]          killz_cnt;

    modport slave (
        input  in_valid, xe_i, ye_i, ze_i, zm_i, xzero_i, yzero_i, zzero_i, tag_i, out_ready,
        output in_ready, out_valid, am_o, asticky_o, killprod_o, killz_o, acnt_o, tag_o,
               killprod_cnt, killz_cnt
    );

    modport master (
        output in_valid, xe_i, ye_i, ze_i, zm_i, xzero_i, yzero_i, zzero_i, tag_i, out_ready,
        input  in_ready, out_valid, am_o, asticky_o, killprod_o, killz_o, acnt_o, tag_o,
               killprod_cnt, killz_cnt
    );
endinterface

// File: rtl/fma_align_pipe.sv
// Two-stage elastic addend aligner: stage 1 computes the alignment count and kill flags, stage 2 shifts Zm.
// Define FMA_ALIGN_STATS_EN to enable saturating kill counters; otherwise both counter ports read 0.
module fma_align_pipe #(
    parameter int NE   = 5,
    parameter int NF   = 10,
    parameter int BIAS = 2**(NE-1)-1,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    fma_align_pipe_if.slave bus
);
    localparam int AMW  = 3*NF+4;
    localparam int SHW  = 4*NF+4;
    localparam int CW   = NE+4;
    localparam int KMAX = 3*NF+3;

    typedef logic signed [CW-1:0] cnt_t;

    function automatic cnt_t align_count(input logic [NE-1:0] xe, input logic [NE-1:0] ye,
                                         input logic [NE-1:0] ze);
        return cnt_t'(xe) + cnt_t'(ye) - cnt_t'(ze) - cnt_t'(BIAS) + cnt_t'(NF + 2);
    endfunction

    logic            s1_adv, s2_adv;
    cnt_t            acnt_in;
    logic            kp_in;
    logic [SHW-1:0]  zpre, zsh;

    logic            s1_valid_q, s1_valid_d;
    cnt_t            s1_acnt_q, s1_acnt_d;
    logic            s1_killprod_q, s1_killprod_d;
    logic            s1_killz_q, s1_killz_d;
    logic [NF:0]     s1_zm_q, s1_zm_d;
    logic            s1_zzero_q, s1_zzero_d;
    logic            s1_xzero_q, s1_xzero_d;
    logic            s1_yzero_q, s1_yzero_d;
    logic [TAGW-1:0] s1_tag_q, s1_tag_d;

    logic            s2_valid_q, s2_valid_d;
    logic [AMW-1:0]  am_q, am_d;
    logic            asticky_q, asticky_d;
    logic            killprod_q, killprod_d;
    logic            killz_q, killz_d;
    cnt_t            acnt_q, acnt_d;
    logic [TAGW-1:0] tag_q, tag_d;

    always_comb begin
        s2_adv = ~s2_valid_q | bus.out_ready;
        s1_adv = ~s1_valid_q | s2_adv;
    end

    // stage 1: alignment count and kill decision
    always_comb begin
        acnt_in       = align_count(bus.xe_i, bus.ye_i, bus.ze_i);
        kp_in         = acnt_in[CW-1] | bus.xzero_i | bus.yzero_i;
        s1_valid_d    = s1_valid_q;
        s1_acnt_d     = s1_acnt_q;
        s1_killprod_d = s1_killprod_q;
        s1_killz_d    = s1_killz_q;
        s1_zm_d       = s1_zm_q;
        s1_zzero_d    = s1_zzero_q;
        s1_xzero_d    = s1_xzero_q;
        s1_yzero_d    = s1_yzero_q;
        s1_tag_d      = s1_tag_q;
        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_acnt_d     = acnt_in;
                s1_killprod_d = kp_in;
                s1_killz_d    = ~kp_in & (acnt_in > cnt_t'(KMAX));
                s1_zm_d       = bus.zm_i;
                s1_zzero_d    = bus.zzero_i;
                s1_xzero_d    = bus.xzero_i;
                s1_yzero_d    = bus.yzero_i;
                s1_tag_d      = bus.tag_i;
            end
        end
    end

    // stage 2: shift Zm into the product frame
    always_comb begin
        zpre       = {s1_zm_q, {(SHW-NF-1){1'b0}}};
        zsh        = zpre >> s1_acnt_q;
        s2_valid_d = s2_valid_q;
        am_d       = am_q;
        asticky_d  = asticky_q;
        killprod_d = killprod_q;
        killz_d    = killz_q;
        acnt_d     = acnt_q;
        tag_d      = tag_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                acnt_d     = s1_acnt_q;
                tag_d      = s1_tag_q;
                killprod_d = s1_killprod_q;
                killz_d    = s1_killz_q;
                if (s1_killprod_q) begin
                    am_d      = AMW'(s1_zm_q) << (2*NF+3);
                    asticky_d = ~(s1_xzero_q | s1_yzero_q);
                end else if (s1_killz_q) begin
                    am_d      = '0;
                    asticky_d = ~s1_zzero_q;
                end else begin
                    am_d      = zsh[SHW-1:NF];
                    asticky_d = |zsh[NF-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_acnt_q     <= '0;
            s1_killprod_q <= 1'b0;
            s1_killz_q    <= 1'b0;
            s1_zm_q       <= '0;
            s1_zzero_q    <= 1'b0;
            s1_xzero_q    <= 1'b0;
            s1_yzero_q    <= 1'b0;
            s1_tag_q      <= '0;
            s2_valid_q    <= 1'b0;
            am_q          <= '0;
            asticky_q     <= 1'b0;
            killprod_q    <= 1'b0;
            killz_q       <= 1'b0;
            acnt_q        <= '0;
            tag_q         <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_acnt_q     <= s1_acnt_d;
            s1_killprod_q <= s1_killprod_d;
            s1_killz_q    <= s1_killz_d;
            s1_zm_q       <= s1_zm_d;
            s1_zzero_q    <= s1_zzero_d;
            s1_xzero_q    <= s1_xzero_d;
            s1_yzero_q    <= s1_yzero_d;
            s1_tag_q      <= s1_tag_d;
            s2_valid_q    <= s2_valid_d;
            am_q          <= am_d;
            asticky_q     <= asticky_d;
            killprod_q    <= killprod_d;
            killz_q       <= killz_d;
            acnt_q        <= acnt_d;
            tag_q         <= tag_d;
        end
    end

    assign bus.in_ready   = s1_adv;
    assign bus.out_valid  = s2_valid_q;
    assign bus.am_o       = am_q;
    assign bus.asticky_o  = asticky_q;
    assign bus.killprod_o = killprod_q;
    assign bus.killz_o    = killz_q;
    assign bus.acnt_o     = acnt_q;
    assign bus.tag_o      = tag_q;

`ifdef FMA_ALIGN_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    logic [15:0] killprod_cnt_q, killprod_cnt_d;
    logic [15:0] killz_cnt_q, killz_cnt_d;

    always_comb begin
        killprod_cnt_d = sat_inc(killprod_cnt_q, s2_valid_q & bus.out_ready & killprod_q);
        killz_cnt_d    = sat_inc(killz_cnt_q, s2_valid_q & bus.out_ready & killz_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            killprod_cnt_q <= '0;
            killz_cnt_q    <= '0;
        end else begin
            killprod_cnt_q <= killprod_cnt_d;
            killz_cnt_q    <= killz_cnt_d;
        end
    end

    assign bus.killprod_cnt = killprod_cnt_q;
    assign bus.killz_cnt    = killz_cnt_q;
`else
    assign bus.killprod_cnt = 16'd0;
    assign bus.killz_cnt    = 16'd0;
`endif
endmodule

// File: tb/tb_fma_align_pipe.sv
// Bench for fma_align_pipe: directed cases, backpressure, async reset and randomised traffic
// checked against an arithmetic model of the alignment.
`timescale 1ns/1ps
module tb_fma_align_pipe;
    localparam int NE   = 5;
    localparam int NF   = 10;
    localparam int TAGW = 4;
    localparam int BIAS = 15;
    localparam int AMW  = 3*NF+4;
    localparam int CW   = NE+4;

    typedef struct packed {
        logic [AMW-1:0]  am;
        logic            sticky;
        logic            kp;
        logic            kz;
        logic [CW-1:0]   acnt;
        logic [TAGW-1:0] tag;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   kp_seen = 0;
    int   kz_seen = 0;
    bit   prev_stall = 0;
    logic [50:0] prev_out;
    bit   rnd_done = 0;

    fma_align_pipe_if #(.NE(NE), .NF(NF), .TAGW(TAGW)) bus ();

    fma_align_pipe #(.NE(NE), .NF(NF), .BIAS(BIAS), .TAGW(TAGW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t",
                     name, $signed(act), act, $signed(req), req, $time);
        end
    endtask

    // Addend value is zm * 2^(3NF+3) in a frame whose LSB weight is 2^acnt; am keeps bits >= NF.
    function automatic exp_t model(input int xe, input int ye, input int ze, input int zm,
                                   input bit xz, input bit yz, input bit zz, input int tag);
        exp_t   e;
        longint ac, full, denom;
        ac   = longint'(xe) + ye - BIAS - ze + NF + 2;
        e.kp = (ac < 0) || xz || yz;
        e.kz = !e.kp && (ac > 3*NF+3);
        if (e.kp) begin
            e.am     = AMW'(longint'(zm) * (longint'(1) << (2*NF+3)));
            e.sticky = !(xz || yz);
        end else if (e.kz) begin
            e.am     = '0;
            e.sticky = !zz;
        end else begin
            full     = longint'(zm) * (longint'(1) << (3*NF+3));
            denom    = longint'(1) << (ac + NF);
            e.am     = AMW'(full / denom);
            e.sticky = (full % denom) != 0;
        end
        e.acnt = CW'(ac);
        e.tag  = TAGW'(tag);
        return e;
    endfunction

    // Scoreboard: samples on the falling edge, between the rising edges where transfers occur.
    always @(negedge clk) begin
        logic [50:0] out_now;
        exp_t        e;
        if (!reset_n) begin
            q.delete();
            kp_seen    = 0;
            kz_seen    = 0;
            prev_stall = 0;
        end else begin
            out_now = {bus.out_valid, bus.am_o, bus.asticky_o, bus.killprod_o, bus.killz_o,
                       bus.acnt_o, bus.tag_o};
            if (prev_stall) check("hold_stable", 64'(out_now), 64'(prev_out));
`ifdef FMA_ALIGN_STATS_EN
            check("killprod_cnt", 64'(bus.killprod_cnt), 64'(kp_seen));
            check("killz_cnt", 64'(bus.killz_cnt), 64'(kz_seen));
`else
            check("killprod_cnt", 64'(bus.killprod_cnt), 64'(0));
            check("killz_cnt", 64'(bus.killz_cnt), 64'(0));
`endif
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 64'(bus.out_valid), 64'(0));
                end else begin
                    e = q.pop_front();
                    check("sb_tag", 64'(bus.tag_o), 64'(e.tag));
                    check("sb_acnt", 64'($signed(bus.acnt_o)), 64'($signed(e.acnt)));
                    check("sb_am", 64'(bus.am_o), 64'(e.am));
                    check("sb_sticky", 64'(bus.asticky_o), 64'(e.sticky));
                    check("sb_killprod", 64'(bus.killprod_o), 64'(e.kp));
                    check("sb_killz", 64'(bus.killz_o), 64'(e.kz));
                    if (e.kp) kp_seen++;
                    if (e.kz) kz_seen++;
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(int'(bus.xe_i), int'(bus.ye_i), int'(bus.ze_i), int'(bus.zm_i),
                                  bit'(bus.xzero_i), bit'(bus.yzero_i), bit'(bus.zzero_i),
                                  int'(bus.tag_i)));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = out_now;
        end
    end

    task automatic drive_op(input int xe, input int ye, input int ze, input int zm,
                            input bit xz, input bit yz, input bit zz, input int tag);
        bus.xe_i     = NE'(xe);
        bus.ye_i     = NE'(ye);
        bus.ze_i     = NE'(ze);
        bus.zm_i     = (NF+1)'(zm);
        bus.xzero_i  = xz;
        bus.yzero_i  = yz;
        bus.zzero_i  = zz;
        bus.tag_i    = TAGW'(tag);
        bus.in_valid = 1'b1;
    endtask

    // Presents an op (called just after a rising edge) and holds it until accepted.
    task automatic send(input int xe, input int ye, input int ze, input int zm,
                        input bit xz, input bit yz, input bit zz, input int tag);
        int waited = 0;
        drive_op(xe, ye, ze, zm, xz, yz, zz, tag);
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.in_ready && waited < 200);
        if (!bus.in_ready) check("accept_timeout", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic directed(input string nm, input int xe, input int ye, input int ze, input int zm,
                            input bit xz, input bit yz, input bit zz, input int tag,
                            input int acnt_x, input longint am_x, input bit st_x,
                            input bit kp_x, input bit kz_x);
        exp_t m;
        int   lat;
        m = model(xe, ye, ze, zm, xz, yz, zz, tag);
        check({nm, "_model_am"}, 64'(m.am), 64'(am_x));
        check({nm, "_model_acnt"}, 64'($signed(m.acnt)), 64'(acnt_x));
        @(posedge clk); #1;
        check({nm, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        drive_op(xe, ye, ze, zm, xz, yz, zz, tag);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (bus.out_valid || lat >= 10) break;
            @(posedge clk);
            lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'(2));
        check({nm, "_acnt"}, 64'($signed(bus.acnt_o)), 64'(acnt_x));
        check({nm, "_am"}, 64'(bus.am_o), 64'(am_x));
        check({nm, "_sticky"}, 64'(bus.asticky_o), 64'(st_x));
        check({nm, "_killprod"}, 64'(bus.killprod_o), 64'(kp_x));
        check({nm, "_killz"}, 64'(bus.killz_o), 64'(kz_x));
        check({nm, "_tag"}, 64'(bus.tag_o), 64'(tag));
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        check({nm, "_outs"}, 64'({bus.am_o, bus.asticky_o, bus.killprod_o, bus.killz_o,
                                  bus.acnt_o, bus.tag_o}), 64'(0));
        check({nm, "_cnts"}, 64'({bus.killprod_cnt, bus.killz_cnt}), 64'(0));
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_drained"}, 64'(q.size()), 64'(0));
    endtask

    task automatic random_op(input int tag);
        int xe, ye, ze, zm, t;
        bit xz, yz, zz;
        xe = int'($urandom_range(0, 31));
        ye = int'($urandom_range(0, 31));
        ze = int'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 0) begin
            t  = int'($urandom_range(0, 39)) - 3;
            ze = xe + ye - BIAS + NF + 2 - t;
            if (ze < 0 || ze > 31) ze = int'($urandom_range(0, 31));
        end
        xz = ($urandom_range(0, 9) == 0);
        yz = ($urandom_range(0, 9) == 0);
        zz = ($urandom_range(0, 9) == 0);
        zm = int'(($urandom_range(0, 9) == 0) ? $urandom_range(1, 1023) : (32'h400 | $urandom_range(0, 1023)));
        if (zz) zm = 0;
        send(xe, ye, ze, zm, xz, yz, zz, tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        bus.out_ready = 1'b1;
        drive_op(0, 0, 0, 0, 0, 0, 0, 0);
        bus.in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", 64'(bus.in_ready), 64'(1));

        directed("dflt",     15, 15, 15, 'h400, 0, 0, 0, 1, 12,  64'h0_0020_0000, 0, 0, 0);
        directed("killz",    30, 30,  1, 'h400, 0, 0, 0, 2, 56,  64'h0,           1, 0, 1);
        directed("killz_zz", 30, 30,  1, 0,     0, 0, 1, 3, 56,  64'h0,           0, 0, 1);
        directed("killp",     1,  1, 30, 'h400, 0, 0, 0, 4, -31, 64'h2_0000_0000, 1, 1, 0);
        directed("killp_yz", 20, 20, 10, 'h400, 0, 1, 0, 5, 27,  64'h2_0000_0000, 0, 1, 0);
        directed("edge33",   30, 21, 15, 'h7FF, 0, 0, 0, 6, 33,  64'h1,           1, 0, 0);
        directed("edge34",   30, 22, 15, 'h400, 0, 0, 0, 7, 34,  64'h0,           1, 0, 1);
        directed("acnt0",    10,  8, 15, 'h5A3, 0, 0, 0, 8, 0,   64'h2_D180_0000, 0, 0, 0);
        directed("acntm1",   10,  7, 15, 'h400, 0, 0, 0, 9, -1,  64'h2_0000_0000, 1, 1, 0);
        directed("zzero",    15, 15, 15, 0,     0, 0, 1, 10, 12, 64'h0,           0, 0, 0);

        // Backpressure: four back-to-back ops against a stalled sink.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        fork
            begin
                send( 1,  1, 30, 'h400, 0, 0, 0, 1);
                send(15, 15, 15, 'h6B1, 0, 0, 0, 2);
                send(30, 30,  1, 'h400, 0, 0, 0, 3);
                send(15, 15, 15, 'h400, 1, 0, 0, 4);
            end
            begin
                repeat (4) @(negedge clk);
                #1;
                check("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
                check("bp_accepts", 64'(q.size()), 64'(2));
                check("bp_out_valid", 64'(bus.out_valid), 64'(1));
                check("bp_head_tag", 64'(bus.tag_o), 64'(1));
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain("bp");

        // Asynchronous reset with both stages occupied.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(15, 15, 15, 'h400, 0, 0, 0, 11);
        send( 1,  1, 30, 'h400, 0, 0, 0, 12);
        check("rst_pre_valid", 64'(bus.out_valid), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        directed("post_rst", 15, 15, 15, 'h400, 0, 0, 0, 13, 12, 64'h0_0020_0000, 0, 0, 0);

        // Randomised traffic with a randomly stalling sink.
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 400; i++) begin
                    random_op(i);
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1;
            end
        join
        wait_drain("rnd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
